cache_mem_arbiter: RTL and testbench
====================================

# cache_mem_arbiter

Two-requester arbiter sharing the single word-at-a-time memory port between the instruction-cache fill engine and the data-cache fill/write engine. It sits between the two caches and the AXI4-Lite bridge. A grant is locked for the whole duration of a requester's held request, so a 4-word line fill is never interleaved. Arbitration is round-robin, and the block reports grant status plus burst-protocol errors.

## Interface
- LINE_WORDS, 4: maximum beats per grant (words per cache line).
- BEAT_W, 3: width of beat counter; must hold LINE_WORDS+1.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- ic_mem_addr  in  32  icache fill word address.
- ic_mem_rd  in  1  icache read request; held high for the whole line fill.
- ic_mem_rdata  out  32  read data to icache.
- ic_mem_valid  out  1  beat accepted/returned to icache.
- dc_mem_addr  in  32  dcache word address.
- dc_mem_rd  in  1  dcache read request; held for the whole fill.
- dc_mem_wr  in  1  dcache write request; held until acknowledged.
- dc_mem_wdata  in  32  write data.
- dc_mem_wstrb  in  4  byte strobes.
- dc_mem_rdata  out  32  read data to dcache.
- dc_mem_valid  out  1  beat/ack to dcache.
- mem_addr  out  32  downstream address.
- mem_rd  out  1  downstream read.
- mem_wr  out  1  downstream write.
- mem_wdata  out  32  downstream write data.
- mem_wstrb  out  4  downstream strobes.
- mem_rdata  in  32  downstream read data.
- mem_valid  in  1  downstream beat complete (read data valid or write ack).
- grant_ic  out  1  icache owns the port.
- grant_dc  out  1  dcache owns the port.
- beat_cnt  out  BEAT_W  beats completed in the current grant.
- err_overrun  out  1  sticky: grant exceeded LINE_WORDS beats.
- err_spurious  out  1  sticky: mem_valid seen while no grant is active.

## Operation
- The state machine has three states: S_IDLE, S_GNT_IC, and S_GNT_DC.
- A requester is requesting when ic_req = ic_mem_rd, or when dc_req = dc_mem_rd | dc_mem_wr.
- **S_IDLE:** if exactly one requester is requesting, go to its grant state. If both are requesting, grant the one that was not granted last (last_gnt register). Both requesters request only when both are pending.
- **S_GNT_IC:** while ic_req is high, stay. When ic_req is low, go to S_GNT_DC if dc_req is high, else go to S_IDLE. S_GNT_DC behaves symmetrically.
- last_gnt updates on entry to a grant state. Its reset value is "dcache", so icache wins the first contention after reset.
- **Downstream mux:** in a grant state, the mem_* outputs are combinational copies of the granted requester's signals. In S_IDLE, the mem_* outputs are all 0.
- **Read data and valid routing:**
  - ic_mem_rdata and dc_mem_rdata = mem_rdata always.
  - ic_mem_valid = mem_valid & (state == S_GNT_IC). dc_mem_valid is the equivalent for S_GNT_DC.
  - The non-granted requester never sees valid.
- **dcache read/write conflict:** dc_mem_rd and dc_mem_wr both high is illegal. dc_mem_wr wins (mem_rd is forced to 0), and the bench assertion flags it.
- **beat_cnt:** clears to 0 on every grant entry, and increments on each mem_valid in a grant state. It saturates at 2^BEAT_W−1.
- **err_overrun:** set when mem_valid arrives while beat_cnt == LINE_WORDS.
- **err_spurious:** set when mem_valid arrives in S_IDLE; that beat is dropped.
- Both error flags are cleared only by reset.

## Timing
- **Reset values:** state S_IDLE, every mem_* output 0, both valids 0, grant_ic and grant_dc 0, beat_cnt 0, both err flags 0. Reset mid-burst aborts immediately, and the next grant follows normal rules.
- **Arbitration latency:** a request first seen in S_IDLE at cycle N gives grant_* and the downstream strobe at N+1.
- **Inside a grant:** zero added latency. The mem_valid to requester path is combinational.
- **Handover:** the requester drops its request in cycle M (the cycle after its last beat). The other requester's grant is visible at M+1, so there is exactly one dead cycle on the port between grants.
- A requester that drops and re-raises its request in consecutive cycles loses to a pending other requester (round-robin).
- grant_ic and grant_dc are registered, decoded from state, and never both high.

## Structure
- Put arb_state_e {S_IDLE, S_GNT_IC, S_GNT_DC} and the ARB_REQ_IC/ARB_REQ_DC encodings for last_gnt in brv32p_pkg.
- Use no sub-module: the 2-input round-robin pick and the mux are small enough to implement inline.
- Use one always_ff for state, last_gnt, beat_cnt, and the err flags, and one always_comb for the mux and next state.

## Test plan
- **Reset then single fill:** ic_mem_rd is raised at cycle 2 with addr 0x100. Required: grant_ic=1 at cycle 3, and mem_addr tracks 0x100, 0x104, 0x108, 0x10C. ic_mem_valid pulses 4 times, beat_cnt reaches 4, and grant_ic drops the cycle after ic_mem_rd falls.
- **Simultaneous first requests:** ic and dc both request at cycle 2. Required: icache is granted first, dcache is granted exactly one cycle after ic_req drops, and dc_mem_valid stays 0 throughout the icache burst.
- **Round-robin fairness:** both requesters request continuously with back-to-back 4-beat fills. Required: grants alternate IC, DC, IC, DC, and neither requester is granted twice in a row.
- **dcache write:** dc_mem_wr=1, addr 0x2000_0010, wdata 0xDEADBEEF, wstrb 0x3. Required: the mem_* outputs mirror these values, a single mem_valid acks it, and mem_rd stays 0 even if dc_mem_rd is also high.
- **Errors:** mem_valid is pulsed in S_IDLE, giving err_spurious=1 with no valid forwarded. Then 5 beats are driven in one icache grant, giving err_overrun=1 on the 5th beat; both flags hold until rst_n.
- **Mid-burst reset:** rst_n is asserted after beat 2 of a dcache fill. Required: all outputs are 0 immediately, and after release a new icache request is granted with beat_cnt=0.

Source files
------------

// File: rtl/brv32p_pkg.sv
// Shared types for the cache memory-port arbiter.
//   arb_state_e : arbiter FSM states.
//   arb_req_e   : identifies a requester; used to remember the last grant
//                 so that contention alternates between the caches.
package brv32p_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GNT_IC = 2'd1,
    S_GNT_DC = 2'd2
  } arb_state_e;

  typedef enum logic {
    ARB_REQ_IC = 1'b0,
    ARB_REQ_DC = 1'b1
  } arb_req_e;

endpackage

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter
// Round-robin arbiter sharing one word-at-a-time memory port between the
// icache fill engine and the dcache fill/write engine. A grant is held for
// as long as the owner keeps its request high, so line fills never
// interleave.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   ic_mem_*                    icache read side (addr/rd in, rdata/valid out)
//   dc_mem_*                    dcache read/write side
//   mem_*                       downstream port toward the AXI4-Lite bridge
//   grant_ic, grant_dc          current port owner
//   beat_cnt                    beats completed in the current grant
//   err_overrun, err_spurious   sticky protocol error flags
module cache_mem_arbiter
  import brv32p_pkg::*;
#(
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned BEAT_W     = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       ic_mem_addr,
  input  logic              ic_mem_rd,
  output logic [31:0]       ic_mem_rdata,
  output logic              ic_mem_valid,
  input  logic [31:0]       dc_mem_addr,
  input  logic              dc_mem_rd,
  input  logic              dc_mem_wr,
  input  logic [31:0]       dc_mem_wdata,
  input  logic [3:0]        dc_mem_wstrb,
  output logic [31:0]       dc_mem_rdata,
  output logic              dc_mem_valid,
  output logic [31:0]       mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_valid,
  output logic              grant_ic,
  output logic              grant_dc,
  output logic [BEAT_W-1:0] beat_cnt,
  output logic              err_overrun,
  output logic              err_spurious
);

  arb_state_e state, state_next;
  arb_req_e   last_gnt;
  logic       ic_req, dc_req;
  logic       grant_entry;

  assign ic_req = ic_mem_rd;
  assign dc_req = dc_mem_rd | dc_mem_wr;

  // State register plus grant bookkeeping and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      last_gnt     <= ARB_REQ_DC;
      beat_cnt     <= '0;
      err_overrun  <= 1'b0;
      err_spurious <= 1'b0;
    end else begin
      state <= state_next;

      if (grant_entry) begin
        beat_cnt <= '0;
      end else if (mem_valid && (state != S_IDLE) && (beat_cnt != '1)) begin
        beat_cnt <= beat_cnt + 1'b1;
      end

      if (state_next == S_GNT_IC && state != S_GNT_IC) begin
        last_gnt <= ARB_REQ_IC;
      end else if (state_next == S_GNT_DC && state != S_GNT_DC) begin
        last_gnt <= ARB_REQ_DC;
      end

      if (mem_valid && (state != S_IDLE) && (beat_cnt == BEAT_W'(LINE_WORDS))) begin
        err_overrun <= 1'b1;
      end
      if (mem_valid && (state == S_IDLE)) begin
        err_spurious <= 1'b1;
      end
    end
  end

  // Next-state: a dropped request hands the port straight to a pending
  // other requester, which gives the single dead cycle between grants.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: begin
        if (ic_req && dc_req) begin
          state_next = (last_gnt == ARB_REQ_DC) ? S_GNT_IC : S_GNT_DC;
        end else if (ic_req) begin
          state_next = S_GNT_IC;
        end else if (dc_req) begin
          state_next = S_GNT_DC;
        end
      end
      S_GNT_IC: begin
        if (!ic_req) state_next = dc_req ? S_GNT_DC : S_IDLE;
      end
      S_GNT_DC: begin
        if (!dc_req) state_next = ic_req ? S_GNT_IC : S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    grant_entry = (state_next != state) && (state_next != S_IDLE);
  end

  // Output decode and downstream mux.
  always_comb begin
    mem_addr     = '0;
    mem_rd       = 1'b0;
    mem_wr       = 1'b0;
    mem_wdata    = '0;
    mem_wstrb    = '0;
    grant_ic     = (state == S_GNT_IC);
    grant_dc     = (state == S_GNT_DC);
    ic_mem_rdata = mem_rdata;
    dc_mem_rdata = mem_rdata;
    ic_mem_valid = mem_valid & grant_ic;
    dc_mem_valid = mem_valid & grant_dc;
    unique case (state)
      S_GNT_IC: begin
        mem_addr = ic_mem_addr;
        mem_rd   = ic_mem_rd;
      end
      S_GNT_DC: begin
        mem_addr  = dc_mem_addr;
        // an illegal simultaneous read+write resolves to the write
        mem_rd    = dc_mem_rd & ~dc_mem_wr;
        mem_wr    = dc_mem_wr;
        mem_wdata = dc_mem_wdata;
        mem_wstrb = dc_mem_wstrb;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed self-checking bench for cache_mem_arbiter.
module tb_cache_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ic_mem_addr, dc_mem_addr, dc_mem_wdata, mem_rdata;
  logic        ic_mem_rd, dc_mem_rd, dc_mem_wr, mem_valid;
  logic [3:0]  dc_mem_wstrb;
  logic [31:0] ic_mem_rdata, dc_mem_rdata, mem_addr, mem_wdata;
  logic        ic_mem_valid, dc_mem_valid, mem_rd, mem_wr;
  logic [3:0]  mem_wstrb;
  logic        grant_ic, grant_dc, err_overrun, err_spurious;
  logic [2:0]  beat_cnt;

  int checks   = 0;
  int failures = 0;

  cache_mem_arbiter #(.LINE_WORDS(4), .BEAT_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .ic_mem_addr(ic_mem_addr), .ic_mem_rd(ic_mem_rd),
    .ic_mem_rdata(ic_mem_rdata), .ic_mem_valid(ic_mem_valid),
    .dc_mem_addr(dc_mem_addr), .dc_mem_rd(dc_mem_rd), .dc_mem_wr(dc_mem_wr),
    .dc_mem_wdata(dc_mem_wdata), .dc_mem_wstrb(dc_mem_wstrb),
    .dc_mem_rdata(dc_mem_rdata), .dc_mem_valid(dc_mem_valid),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid),
    .grant_ic(grant_ic), .grant_dc(grant_dc), .beat_cnt(beat_cnt),
    .err_overrun(err_overrun), .err_spurious(err_spurious)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ic_mem_rd = 1'b0; dc_mem_rd = 1'b0; dc_mem_wr = 1'b0; mem_valid = 1'b0;
    ic_mem_addr = '0; dc_mem_addr = '0; dc_mem_wdata = '0; dc_mem_wstrb = '0;
    mem_rdata = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // One 4-beat fill by the expected owner, then a one-cycle drop/re-raise
  // of its request while the other requester stays pending.
  task automatic run_fill(input logic exp_ic);
    chk("rr_grant_ic", {31'd0, grant_ic}, {31'd0, exp_ic});
    chk("rr_grant_dc", {31'd0, grant_dc}, {31'd0, ~exp_ic});
    chk("rr_beat0", {29'd0, beat_cnt}, 32'd0);
    mem_valid = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      mem_rdata = 32'hA000_0000 + i;
      #1;
      chk("rr_ic_valid", {31'd0, ic_mem_valid}, {31'd0, exp_ic});
      chk("rr_dc_valid", {31'd0, dc_mem_valid}, {31'd0, ~exp_ic});
      tick();
    end
    mem_valid = 1'b0;
    chk("rr_beat4", {29'd0, beat_cnt}, 32'd4);
    if (exp_ic) ic_mem_rd = 1'b0; else dc_mem_rd = 1'b0;
    #1;
    chk("rr_dead_rd", {31'd0, mem_rd}, 32'd0);
    chk("rr_dead_hold", {31'd0, grant_ic}, {31'd0, exp_ic});
    tick();
    if (exp_ic) ic_mem_rd = 1'b1; else dc_mem_rd = 1'b1;
    #1;
    chk("rr_switch_ic", {31'd0, grant_ic}, {31'd0, ~exp_ic});
    chk("rr_switch_dc", {31'd0, grant_dc}, {31'd0, exp_ic});
  endtask

  initial begin
    // ---- reset state
    do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_grant_ic", {31'd0, grant_ic}, 32'd0);
    chk("rst_grant_dc", {31'd0, grant_dc}, 32'd0);
    chk("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_beat", {29'd0, beat_cnt}, 32'd0);
    chk("rst_errs", {30'd0, err_overrun, err_spurious}, 32'd0);
    rst_n = 1'b1;

    // ---- single icache fill
    tick();
    ic_mem_rd = 1'b1; ic_mem_addr = 32'h100;
    #1;
    chk("fill_no_grant_yet", {31'd0, grant_ic}, 32'd0);
    tick();
    chk("fill_grant_ic", {31'd0, grant_ic}, 32'd1);
    chk("fill_mem_rd", {31'd0, mem_rd}, 32'd1);
    for (int unsigned i = 0; i < 4; i++) begin
      ic_mem_addr = 32'h100 + 4 * i;
      mem_valid = 1'b1; mem_rdata = 32'h5500 + i;
      #1;
      chk("fill_addr", mem_addr, 32'h100 + 4 * i);
      chk("fill_ic_valid", {31'd0, ic_mem_valid}, 32'd1);
      chk("fill_rdata", ic_mem_rdata, 32'h5500 + i);
      chk("fill_dc_valid", {31'd0, dc_mem_valid}, 32'd0);
      tick();
    end
    mem_valid = 1'b0;
    chk("fill_beat4", {29'd0, beat_cnt}, 32'd4);
    ic_mem_rd = 1'b0;
    #1;
    chk("fill_drop_hold", {31'd0, grant_ic}, 32'd1);
    tick();
    chk("fill_released", {31'd0, grant_ic}, 32'd0);

    // ---- simultaneous first requests, then round-robin alternation
    do_reset();
    tick();
    ic_mem_rd = 1'b1; dc_mem_rd = 1'b1;
    ic_mem_addr = 32'h200; dc_mem_addr = 32'h1000_0000;
    tick();
    run_fill(1'b1);
    chk("sim_dc_addr", mem_addr, 32'h1000_0000);
    run_fill(1'b0);
    run_fill(1'b1);
    run_fill(1'b0);
    ic_mem_rd = 1'b0; dc_mem_rd = 1'b0;
    tick();
    tick();
    chk("rr_idle", {30'd0, grant_ic, grant_dc}, 32'd0);

    // ---- dcache write with illegal concurrent read
    do_reset();
    dc_mem_wr = 1'b1; dc_mem_rd = 1'b1;
    dc_mem_addr = 32'h2000_0010; dc_mem_wdata = 32'hDEADBEEF; dc_mem_wstrb = 4'h3;
    tick();
    chk("wr_grant_dc", {31'd0, grant_dc}, 32'd1);
    chk("wr_mem_wr", {31'd0, mem_wr}, 32'd1);
    chk("wr_mem_rd_forced", {31'd0, mem_rd}, 32'd0);
    chk("wr_addr", mem_addr, 32'h2000_0010);
    chk("wr_wdata", mem_wdata, 32'hDEADBEEF);
    chk("wr_wstrb", {28'd0, mem_wstrb}, 32'h3);
    mem_valid = 1'b1;
    #1;
    chk("wr_ack", {31'd0, dc_mem_valid}, 32'd1);
    tick();
    mem_valid = 1'b0; dc_mem_wr = 1'b0; dc_mem_rd = 1'b0;
    #1;
    chk("wr_beat1", {29'd0, beat_cnt}, 32'd1);
    tick();
    tick();
    chk("wr_idle_wr", {31'd0, mem_wr}, 32'd0);
    chk("wr_idle_wdata", mem_wdata, 32'd0);

    // ---- error flags
    mem_valid = 1'b1;
    #1;
    chk("spur_no_valid", {30'd0, ic_mem_valid, dc_mem_valid}, 32'd0);
    tick();
    mem_valid = 1'b0;
    chk("spur_flag", {31'd0, err_spurious}, 32'd1);
    chk("spur_no_overrun", {31'd0, err_overrun}, 32'd0);
    ic_mem_rd = 1'b1; ic_mem_addr = 32'h400;
    tick();
    chk("ovr_grant", {31'd0, grant_ic}, 32'd1);
    mem_valid = 1'b1;
    for (int unsigned i = 0; i < 4; i++) tick();
    chk("ovr_beat4", {29'd0, beat_cnt}, 32'd4);
    chk("ovr_not_yet", {31'd0, err_overrun}, 32'd0);
    tick();
    chk("ovr_flag", {31'd0, err_overrun}, 32'd1);
    chk("ovr_beat5", {29'd0, beat_cnt}, 32'd5);
    mem_valid = 1'b0; ic_mem_rd = 1'b0;
    tick();
    tick();
    chk("err_sticky", {30'd0, err_overrun, err_spurious}, 32'd3);
    do_reset();
    #1;
    chk("err_cleared", {30'd0, err_overrun, err_spurious}, 32'd0);

    // ---- mid-burst reset
    dc_mem_rd = 1'b1; dc_mem_addr = 32'h300;
    tick();
    chk("mid_grant_dc", {31'd0, grant_dc}, 32'd1);
    mem_valid = 1'b1;
    tick();
    tick();
    chk("mid_beat2", {29'd0, beat_cnt}, 32'd2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_grant", {30'd0, grant_ic, grant_dc}, 32'd0);
    chk("mid_rst_rd", {31'd0, mem_rd}, 32'd0);
    chk("mid_rst_addr", mem_addr, 32'd0);
    chk("mid_rst_beat", {29'd0, beat_cnt}, 32'd0);
    chk("mid_rst_valid", {31'd0, dc_mem_valid}, 32'd0);
    mem_valid = 1'b0; dc_mem_rd = 1'b0;
    tick();
    rst_n = 1'b1;
    ic_mem_rd = 1'b1; ic_mem_addr = 32'h500;
    tick();
    chk("post_rst_grant_ic", {31'd0, grant_ic}, 32'd1);
    chk("post_rst_beat", {29'd0, beat_cnt}, 32'd0);
    chk("post_rst_addr", mem_addr, 32'h500);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
